// File: rtl/cart_pkg.sv
`default_nettype none
// ============================================================================
// cart_pkg
//   Shared constants and state encoding for the cartridge download path.
//   Revision: 1.0
// ============================================================================
package cart_pkg;

  localparam int         PAGE_BITS = 14;
  localparam int         HDR_BYTES = 512;
  localparam logic [7:0] GG_INDEX  = 8'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_SIZE  = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/pow2_mask.sv
`default_nettype none
// ============================================================================
// pow2_mask
//   Registered bit-smear: turns a value into the all-ones mask of its
//   enclosing power of two, saturating at all-ones of the output width.
//   Revision: 1.0
// ============================================================================
module pow2_mask #(
  parameter int N     = 9,
  parameter int OUT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             zero_i,
  input  logic [N-1:0]     val_i,
  output logic [OUT_W-1:0] mask_o
);

  logic [OUT_W-1:0] smear;
  logic [OUT_W-1:0] mask_q;

  // Bit i of the smear is set when any bit at or above i is set, so
  // values wider than the output collapse to all-ones.
  always_comb begin
    smear = '0;
    for (int i = 0; i < OUT_W; i++) begin
      smear[i] = |(val_i >> i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
    end else if (clr_i) begin
      mask_q <= '0;
    end else if (en_i) begin
      mask_q <= zero_i ? '0 : smear;
    end
  end

  assign mask_o = mask_q;

endmodule
`default_nettype wire

// File: rtl/cart_loader.sv
`default_nettype none
// ============================================================================
// cart_loader
//   Streams the HPS cartridge download into SDRAM over the toggle write
//   port and derives the page mask and copier-header flag at the end.
//   Revision: 1.0
// ============================================================================
module cart_loader #(
  parameter int AW        = 22,
  parameter int PAGE_BITS = cart_pkg::PAGE_BITS
) (
  input  logic          clk_sys,
  input  logic          RESET_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_dout,
  input  logic [7:0]    ioctl_index,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  input  logic          mem_we_ack,
  output logic [7:0]    cart_mask,
  output logic          hdr_ofs,
  output logic          gg,
  output logic          busy,
  output logic          done
);

  import cart_pkg::*;

  localparam int                   PGW     = AW - PAGE_BITS + 1;
  localparam logic [PAGE_BITS-1:0] HDR_LO  = PAGE_BITS'(HDR_BYTES);
  localparam logic [AW:0]          HDR_SUB = (AW+1)'(HDR_BYTES);

  loader_state_t  state_q, state_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           gg_q, gg_d;
  logic           hdr_q, hdr_d;
  logic           h_q, h_d;
  logic [PGW-1:0] pages_q, pages_d;
  logic           ph_q, ph_d;
  logic [AW-1:0]  waddr_q, waddr_d;
  logic [7:0]     din_q, din_d;
  logic           we_q, we_d;
  logic           wait_q, wait_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dl_prev_q;
  logic           pend_q, pend_d;
  logic           clr_mask;
  logic           mask_en;

  logic           dl_rise;
  logic           hdr_hit;
  logic [AW:0]    p_sz;
  logic [PGW-1:0] pages_sz;

  assign dl_rise = ioctl_download & ~dl_prev_q;

  // Size arithmetic; cnt never exceeds 2^AW so the page count fits in PGW bits.
  assign hdr_hit  = (cnt_q[PAGE_BITS-1:0] == HDR_LO);
  assign p_sz     = cnt_q - (hdr_hit ? HDR_SUB : '0);
  assign pages_sz = p_sz[AW:PAGE_BITS] + PGW'(|p_sz[PAGE_BITS-1:0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    gg_d     = gg_q;
    hdr_d    = hdr_q;
    h_d      = h_q;
    pages_d  = pages_q;
    ph_d     = ph_q;
    waddr_d  = waddr_q;
    din_d    = din_q;
    we_d     = we_q;
    wait_d   = wait_q;
    pend_d   = pend_q | dl_rise;
    clr_mask = 1'b0;
    mask_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dl_rise || pend_q) begin
          state_d  = ST_RECV;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          gg_d     = (ioctl_index == GG_INDEX);
          hdr_d    = 1'b0;
          clr_mask = 1'b1;
          pend_d   = 1'b0;
        end
      end
      ST_RECV: begin
        if (ioctl_wr) begin
          if (!cnt_q[AW]) begin
            waddr_d = cnt_q[AW-1:0];
            din_d   = ioctl_dout;
            we_d    = ~we_q;
            wait_d  = 1'b1;
            state_d = ST_WRITE;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (!ioctl_download) begin
          state_d = ST_SIZE;
          ph_d    = 1'b0;
        end
      end
      ST_WRITE: begin
        if (mem_we_ack == we_q) begin
          wait_d  = 1'b0;
          state_d = ST_RECV;
          if (!cnt_q[AW]) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_SIZE: begin
        if (!ph_q) begin
          h_d     = hdr_hit;
          pages_d = pages_sz;
          ph_d    = 1'b1;
        end else begin
          mask_en = 1'b1;
          hdr_d   = h_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      gg_q      <= 1'b0;
      hdr_q     <= 1'b0;
      h_q       <= 1'b0;
      pages_q   <= '0;
      ph_q      <= 1'b0;
      waddr_q   <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      wait_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dl_prev_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      gg_q      <= gg_d;
      hdr_q     <= hdr_d;
      h_q       <= h_d;
      pages_q   <= pages_d;
      ph_q      <= ph_d;
      waddr_q   <= waddr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dl_prev_q <= ioctl_download;
      pend_q    <= pend_d;
    end
  end

  pow2_mask #(
    .N     (PGW),
    .OUT_W (8)
  ) u_pow2_mask (
    .clk_i  (clk_sys),
    .rst_ni (RESET_n),
    .clr_i  (clr_mask),
    .en_i   (mask_en),
    .zero_i (pages_q == '0),
    .val_i  (pages_q - PGW'(1)),
    .mask_o (cart_mask)
  );

  assign ioctl_wait = wait_q;
  assign mem_waddr  = waddr_q;
  assign mem_din    = din_q;
  assign mem_we     = we_q;
  assign hdr_ofs    = hdr_q;
  assign gg         = gg_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cart_loader.sv
`default_nettype none
// ============================================================================
// tb_cart_loader
//   Randomized self-checking bench for cart_loader with a small SDRAM ack
//   model and a size/mask reference model computed from byte counts.
//   Revision: 1.0
// ============================================================================
module tb_cart_loader;

  localparam int AW   = 12;
  localparam int PB   = 10;
  localparam int PAGE = 1 << PB;
  localparam int MAXB = 1 << AW;

  logic          clk_sys = 1'b0;
  logic          RESET_n = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [7:0]    ioctl_dout = 8'h00;
  logic [7:0]    ioctl_index = 8'h00;
  logic          ioctl_wait;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          mem_we_ack;
  logic [7:0]    cart_mask;
  logic          hdr_ofs;
  logic          gg;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic       ack_r = 1'b0;
  int         ack_pend = 0;
  int         ack_dly = 0;
  logic [7:0] exp_q[$];
  int         sent = 0;
  logic       exp_gg = 1'b0;
  logic       prev_we = 1'b0;
  int         tog_idx = 0;
  logic [AW-1:0] tog_addr = '0;

  wire [33:0] outs_vec = {ioctl_wait, mem_waddr, mem_din, mem_we, cart_mask,
                          hdr_ofs, gg, busy, done};

  assign mem_we_ack = ack_r;

  cart_loader #(
    .AW        (AW),
    .PAGE_BITS (PB)
  ) dut (
    .clk_sys        (clk_sys),
    .RESET_n        (RESET_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .mem_waddr      (mem_waddr),
    .mem_din        (mem_din),
    .mem_we         (mem_we),
    .mem_we_ack     (mem_we_ack),
    .cart_mask      (cart_mask),
    .hdr_ofs        (hdr_ofs),
    .gg             (gg),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference sizing: byte count -> (mask, header) straight from the page rules.
  function automatic void model(input int n, output int mask, output int hdr);
    int nn, p, pages, pw;
    nn    = (n > MAXB) ? MAXB : n;
    hdr   = ((nn % PAGE) == 512) ? 1 : 0;
    p     = nn - 512 * hdr;
    pages = (p + PAGE - 1) / PAGE;
    if (pages == 0) begin
      mask = 0;
    end else begin
      pw = 1;
      while (pw < pages) pw = pw * 2;
      mask = (pw - 1 > 255) ? 255 : pw - 1;
    end
  endfunction

  // SDRAM write side: acknowledges a pending toggle ack_dly cycles after it appears.
  always @(posedge clk_sys) begin
    #1;
    if (!RESET_n) begin
      ack_r    = 1'b0;
      ack_pend = 0;
    end else if (mem_we != ack_r) begin
      if (ack_pend >= ack_dly) begin
        ack_r    = mem_we;
        ack_pend = 0;
      end else begin
        ack_pend++;
      end
    end
  end

  // Write monitor: every toggle must carry the next address and byte in order.
  always @(negedge clk_sys) begin
    if (!busy) begin
      prev_we = mem_we;
      tog_idx = 0;
    end else if (mem_we != prev_we) begin
      prev_we = mem_we;
      check_val("waddr_seq", mem_waddr, tog_idx);
      check_val("byte_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_val("din", mem_din, exp_q.pop_front());
      tog_addr = mem_waddr;
      tog_idx++;
    end else if (ioctl_wait) begin
      check_val("waddr_stable", mem_waddr, tog_addr);
    end
  end

  task automatic start_download(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    sent           = 0;
    exp_gg         = (idx == 8'd2);
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit acc;
    int hi;
    acc = (sent < MAXB);
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_dout = d;
    if (acc) exp_q.push_back(d);
    sent++;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    hi = 0;
    while (ioctl_wait && hi < 64) begin
      hi++;
      @(negedge clk_sys);
    end
    check_val("wait_cycles", hi, acc ? ack_dly + 1 : 0);
  endtask

  task automatic finish_download(input bit rerise, input logic [7:0] next_idx);
    int lat, m, h, wr_exp;
    model(sent, m, h);
    wr_exp = (sent > MAXB) ? MAXB : sent;
    @(negedge clk_sys);
    check_val("busy_recv", busy, 1);
    ioctl_download = 1'b0;
    lat = 0;
    while (!done && lat < 16) begin
      @(negedge clk_sys);
      lat++;
      if (rerise && lat == 1) begin
        ioctl_index    = next_idx;
        ioctl_download = 1'b1;
      end
    end
    check_val("done_latency", lat, 3);
    check_val("writes", tog_idx, wr_exp);
    check_val("bytes_left", exp_q.size(), 0);
    check_val("cart_mask", cart_mask, m);
    check_val("hdr_ofs", hdr_ofs, h);
    check_val("gg", gg, exp_gg);
    @(negedge clk_sys);
    check_val("done_pulse", done, 0);
    check_val("busy_idle", busy, 0);
    if (rerise) begin
      sent   = 0;
      exp_gg = (next_idx == 8'd2);
    end
  endtask

  task automatic run_image(input int n, input int k, input logic [7:0] idx);
    ack_dly = k;
    start_download(idx);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
    finish_download(1'b0, 8'h00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    check_val("reset_outs", outs_vec, 0);
    RESET_n = 1'b1;
    @(negedge clk_sys);
    check_val("idle_outs", outs_vec, 0);

    run_image(2 * PAGE, 0, 8'd0);
    run_image(3 * PAGE, 0, 8'd1);
    run_image(2 * PAGE + 512, 0, 8'd0);
    run_image(16, 7, 8'd0);

    // Empty GG download, with a new window opened while sizing.
    ack_dly = 0;
    start_download(8'd2);
    finish_download(1'b1, 8'd0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    finish_download(1'b0, 8'h00);

    run_image(MAXB + 3, 0, 8'd3);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = (r == 0) ? 512 : int'($urandom_range(1, 1200));
      run_image(n, int'($urandom_range(0, 2)), 8'($urandom_range(0, 3)));
    end

    // Reset during the 100th write's WRITE state.
    ack_dly = 5;
    start_download(8'd2);
    for (int i = 0; i < 99; i++) send_byte(8'($urandom));
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_dout = 8'hA5;
    exp_q.push_back(8'hA5);
    sent++;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check_val("wait_before_rst", ioctl_wait, 1);
    @(negedge clk_sys);
    RESET_n        = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check_val("rst_async_outs", outs_vec, 0);
    repeat (2) @(negedge clk_sys);
    check_val("rst_hold_outs", outs_vec, 0);
    RESET_n = 1'b1;
    @(negedge clk_sys);
    run_image(40, 1, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
